// File: rtl/catch_ctl_pkg.sv
// Shared definitions for the catch controller and the bag generator:
// FSM state encoding and screen geometry constants.
package catch_ctl_pkg;

    typedef enum logic [1:0] {
        WAIT     = 2'd0,
        RESOLVED = 2'd1,
        STUN     = 2'd2
    } state_t;

    localparam int YPOS_START = 100;
    localparam int YPOS_END   = 600;
    localparam int WIDTH      = 48;

endpackage

// File: rtl/catch_ctl_overlap.sv
// Purely combinational horizontal overlap test between bag and catcher sprites.
module catch_overlap #(
    parameter int BAG_WIDTH    = 48,
    parameter int PLAYER_WIDTH = 64
) (
    input  logic [11:0] bag_xpos,
    input  logic [11:0] player_xpos,
    output logic        overlap
);

    logic [12:0] bag_right;
    logic [12:0] player_right;

    // One extra bit so sprite right edges near the screen edge never wrap.
    assign bag_right    = {1'b0, bag_xpos} + 13'(BAG_WIDTH);
    assign player_right = {1'b0, player_xpos} + 13'(PLAYER_WIDTH);

    assign overlap = (bag_right > {1'b0, player_xpos}) &&
                     ({1'b0, bag_xpos} < player_right);

endmodule

// File: rtl/catch_ctl.sv
// Catch/miss/deposit controller with carry and score bookkeeping.
// Optional overload stun is enabled by defining CATCH_OVERLOAD_EN.
module catch_ctl
    import catch_ctl_pkg::*;
#(
    parameter int BAG_WIDTH    = WIDTH,
    parameter int PLAYER_WIDTH = 64,
    parameter int CATCH_Y      = 500,
    parameter int DEPOSIT_X    = 40,
    parameter int MAX_CARRY    = 5,
    parameter int STUN_CYCLES  = 65000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bag_xpos,
    input  logic [11:0] bag_ypos,
    input  logic [11:0] player_xpos,
    output logic        caught,
    output logic        missed,
    output logic        deposited,
    output logic [3:0]  carry,
    output logic [15:0] score,
    output logic        stunned
);

    localparam int STUN_W = (STUN_CYCLES > 1) ? $clog2(STUN_CYCLES) : 1;
    localparam logic [STUN_W-1:0] STUN_LAST = STUN_W'(STUN_CYCLES - 1);

    state_t            state, state_n;
    logic              arm, arm_n;
    logic [STUN_W-1:0] stun_cnt, stun_cnt_n;
    logic [3:0]        carry_n, carry_eff;
    logic [15:0]       score_n;
    logic              caught_n, missed_n, deposited_n;
    logic              below, eval_now, overlap;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    catch_overlap #(
        .BAG_WIDTH    (BAG_WIDTH),
        .PLAYER_WIDTH (PLAYER_WIDTH)
    ) u_overlap (
        .bag_xpos    (bag_xpos),
        .player_xpos (player_xpos),
        .overlap     (overlap)
    );

    always_comb begin
        state_n     = state;
        arm_n       = arm;
        stun_cnt_n  = stun_cnt;
        carry_eff   = carry;
        carry_n     = carry;
        score_n     = score;
        caught_n    = 1'b0;
        missed_n    = 1'b0;
        deposited_n = 1'b0;
        eval_now    = 1'b0;
        below       = (bag_ypos < 12'(CATCH_Y));

        // The arm flag guarantees a bag is judged only after it was seen above the line.
        if (below)
            arm_n = 1'b1;

        case (state)
            WAIT: begin
                if (!below && arm) begin
                    eval_now = 1'b1;
                    arm_n    = 1'b0;
                    state_n  = RESOLVED;
                end
            end
            RESOLVED: begin
                if (below)
                    state_n = WAIT;
            end
            STUN: begin
                if (!below && arm) begin
                    missed_n = 1'b1;
                    arm_n    = 1'b0;
                end
                if (stun_cnt == STUN_LAST) begin
                    stun_cnt_n = '0;
                    state_n    = below ? WAIT : RESOLVED;
                end else begin
                    stun_cnt_n = stun_cnt + 1'b1;
                end
            end
            default: state_n = WAIT;
        endcase

        if (state != STUN) begin
            if (player_xpos <= 12'(DEPOSIT_X) && carry != 4'd0) begin
                score_n     = sat_add(score, carry);
                carry_eff   = 4'd0;
                deposited_n = 1'b1;
            end
            carry_n = carry_eff;
            // A deposit in the catch cycle empties the bag first, so the catch starts from zero.
            if (eval_now) begin
                if (overlap) begin
                    caught_n = 1'b1;
                    if (carry_eff == 4'(MAX_CARRY)) begin
`ifdef CATCH_OVERLOAD_EN
                        carry_n    = 4'd0;
                        state_n    = STUN;
                        stun_cnt_n = '0;
`else
                        carry_n    = carry_eff;
`endif
                    end else begin
                        carry_n = carry_eff + 4'd1;
                    end
                end else begin
                    missed_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT;
            arm       <= 1'b0;
            stun_cnt  <= '0;
            carry     <= 4'd0;
            score     <= 16'd0;
            caught    <= 1'b0;
            missed    <= 1'b0;
            deposited <= 1'b0;
        end else begin
            state     <= state_n;
            arm       <= arm_n;
            stun_cnt  <= stun_cnt_n;
            carry     <= carry_n;
            score     <= score_n;
            caught    <= caught_n;
            missed    <= missed_n;
            deposited <= deposited_n;
        end
    end

`ifdef CATCH_OVERLOAD_EN
    always_ff @(posedge clk) begin
        if (rst)
            stunned <= 1'b0;
        else
            stunned <= (state_n == STUN);
    end
`else
    assign stunned = 1'b0;
`endif

endmodule
